// File: rtl/hcsr04_emulador_pkg.sv
// HC-SR04 emulator shared definitions.
// State codes, default timing constants and BCD helpers.
package hcsr04_emulador_pkg;

  localparam logic [3:0] ST_INICIAL   = 4'd0;
  localparam logic [3:0] ST_ESPERA    = 4'd1;
  localparam logic [3:0] ST_MEDE_TRIG = 4'd2;
  localparam logic [3:0] ST_ATRASO    = 4'd3;
  localparam logic [3:0] ST_ECHO      = 4'd4;
  localparam logic [3:0] ST_HOLDOFF   = 4'd5;

  localparam int TRIG_MIN_DEF      = 500;
  localparam int ECHO_DELAY_DEF    = 10000;
  localparam int CICLOS_POR_CM_DEF = 2941;
  localparam int TIMEOUT_DEF       = 1900000;
  localparam int HOLDOFF_DEF       = 500000;

  localparam int CNT_W = 22;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [9:0] cm;
    logic       bad;
  } bcd_res_t;

  function automatic logic digit_bad(
    input logic [3:0] d
  );
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/hcsr04_emulador_if.sv
// Trigger/echo link between range meter and sensor.
// master = range meter side, slave = sensor side.
interface hcsr04_emulador_if;

  logic        trigger;
  logic [11:0] distancia;
  logic        echo;
  logic        erro_bcd;
  logic [3:0]  db_estado;

  modport master (
    output trigger,
    output distancia,
    input  echo,
    input  erro_bcd,
    input  db_estado
  );

  modport slave (
    input  trigger,
    input  distancia,
    output echo,
    output erro_bcd,
    output db_estado
  );

endinterface

// File: rtl/hcsr04_emulador_bcd2bin.sv
// 3-digit BCD to binary centimetres.
// Flags any digit above 9.
module hcsr04_emulador_bcd2bin
  import hcsr04_emulador_pkg::*;
(
  input  logic [11:0] bcd,
  output bcd_res_t    res
);

  logic [3:0] h;
  logic [3:0] t;
  logic [3:0] u;

  assign h = bcd[11:8];
  assign t = bcd[7:4];
  assign u = bcd[3:0];

  always_comb begin
    res     = '0;
    res.bad = digit_bad(h)
            | digit_bad(t)
            | digit_bad(u);
    res.cm  = 10'(h) * 10'd100
            + 10'(t) * 10'd10
            + 10'(u);
  end

endmodule

// File: rtl/hcsr04_emulador.sv
// HC-SR04 device-side emulator.
// Trigger in, delayed echo whose width encodes a BCD distance.
module hcsr04_emulador
  import hcsr04_emulador_pkg::*;
#(
  parameter int TRIG_MIN_CYCLES   = TRIG_MIN_DEF,
  parameter int ECHO_DELAY_CYCLES = ECHO_DELAY_DEF,
  parameter int CICLOS_POR_CM     = CICLOS_POR_CM_DEF,
  parameter int TIMEOUT_CYCLES    = TIMEOUT_DEF,
  parameter int HOLDOFF_CYCLES    = HOLDOFF_DEF
)(
  input  logic             clock,
  input  logic             reset,
  hcsr04_emulador_if.slave hs
);

  // Loads are N-1: the counter spends one cycle on zero.
  localparam cnt_t TRIG_LOAD  = cnt_t'(TRIG_MIN_CYCLES - 1);
  localparam cnt_t DELAY_LOAD = cnt_t'(ECHO_DELAY_CYCLES - 1);
  localparam cnt_t HOLD_LOAD  = cnt_t'(HOLDOFF_CYCLES - 1);
  localparam cnt_t TOUT_N     = cnt_t'(TIMEOUT_CYCLES);
  localparam cnt_t CPC_N      = cnt_t'(CICLOS_POR_CM);

  logic [3:0]  state;
  logic        trig_m;
  logic        trig_s;
  logic        trig_d;
  cnt_t        cnt;
  cnt_t        n_q;
  cnt_t        n_calc;
  logic [11:0] dist_q;
  logic        echo_q;
  logic        erro_q;
  bcd_res_t    res;

  hcsr04_emulador_bcd2bin u_bcd (
    .bcd (dist_q),
    .res (res)
  );

  always_comb begin
    n_calc = TOUT_N;
    if (!res.bad && res.cm != 10'd0)
      n_calc = cnt_t'(res.cm) * CPC_N;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trig_m <= 1'b0;
      trig_s <= 1'b0;
      trig_d <= 1'b0;
      n_q    <= '0;
      erro_q <= 1'b0;
    end else begin
      trig_m <= hs.trigger;
      trig_s <= trig_m;
      trig_d <= trig_s;
      n_q    <= n_calc;
      erro_q <= res.bad;
    end
  end

  // The first high sample is taken in ESPERA, hence TRIG_MIN-1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_INICIAL;
      cnt    <= '0;
      dist_q <= '0;
      echo_q <= 1'b0;
    end else begin
      unique case (state)
        ST_INICIAL: begin
          state <= ST_ESPERA;
        end
        ST_ESPERA: begin
          if (trig_s && !trig_d) begin
            state <= ST_MEDE_TRIG;
            cnt   <= TRIG_LOAD;
          end
        end
        ST_MEDE_TRIG: begin
          if (!trig_s) begin
            if (cnt == '0) begin
              dist_q <= hs.distancia;
              cnt    <= DELAY_LOAD;
              state  <= ST_ATRASO;
            end else begin
              state <= ST_ESPERA;
            end
          end else if (cnt != '0) begin
            cnt <= cnt - cnt_t'(1);
          end
        end
        ST_ATRASO: begin
          if (cnt == '0) begin
            state  <= ST_ECHO;
            echo_q <= 1'b1;
            cnt    <= n_q - cnt_t'(1);
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end
        ST_ECHO: begin
          if (cnt == '0) begin
            state  <= ST_HOLDOFF;
            echo_q <= 1'b0;
            cnt    <= HOLD_LOAD;
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end
        ST_HOLDOFF: begin
          if (cnt == '0)
            state <= ST_ESPERA;
          else
            cnt <= cnt - cnt_t'(1);
        end
        default: begin
          state  <= ST_INICIAL;
          echo_q <= 1'b0;
        end
      endcase
    end
  end

  assign hs.echo      = echo_q;
  assign hs.erro_bcd  = erro_q;
  assign hs.db_estado = state;

endmodule
